tx_bit_stuffer: RTL and testbench
=================================

# tx_bit_stuffer

Bit stuffer for the CDL USB transmit path. It sits between the TX shift register and the NRZI encoder. After every run of RUN_LENGTH consecutive 1s it inserts one 0 into the outgoing bit stream, and it holds the shift register for that inserted bit period. It is the transmit-side counterpart of the RX bit-stuff detector: every stream it emits must be de-stuffable by that detector back to the original raw stream.

## Interface
Parameters:
- RUN_LENGTH, default 6: number of consecutive 1s that triggers a stuffed 0. Legal range is 2..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high
- shift_enable  input  1  one-cycle strobe, once per USB bit period, from the TX bit timer
- stuff_en  input  1  high while stuffable packet bits (SYNC through CRC) are being sent; low during idle/EOP
- raw_bit  input  1  current unstuffed bit presented by the TX shift register; sampled when shift_enable=1
- tx_bit  output  1  registered bit to the NRZI encoder
- bit_strobe  output  1  registered one-cycle pulse, high the cycle after a sampled shift_enable; marks a new tx_bit
- hold  output  1  registered; high while a stuffed 0 is pending; the shift register must not advance on shift_enable while hold=1

## Operation
- The FSM has three states: IDLE, ACTIVE and STUFF. It uses a 3-bit run counter `cnt` (0..RUN_LENGTH-1) and a registered tx_bit.
- When rst=1 (this has priority over all other inputs), the block loads:
  - state=IDLE, cnt=0
  - tx_bit=1, bit_strobe=0, hold=0
- On a clock where shift_enable=0, there is no state change, tx_bit holds its value, and bit_strobe is 0 in the next cycle.
- On a clock where shift_enable=1, the block sets bit_strobe to 1 in the next cycle, then acts by state:
  - **IDLE, stuff_en=0:** tx_bit<=raw_bit, cnt<=0, stay in IDLE. There is no stuffing.
  - **IDLE or ACTIVE, stuff_en=1:** tx_bit<=raw_bit, then:
    - raw_bit=0: cnt<=0, go to ACTIVE.
    - raw_bit=1 with cnt<RUN_LENGTH-1: cnt<=cnt+1, go to ACTIVE.
    - raw_bit=1 with cnt==RUN_LENGTH-1: cnt<=0, go to STUFF.
  - **ACTIVE, stuff_en=0:** tx_bit<=raw_bit, cnt<=0, go to IDLE.
  - **STUFF (any stuff_en):** tx_bit<=0 and raw_bit is ignored (not consumed), cnt<=0.
    - Next state is ACTIVE if stuff_en=1, otherwise IDLE.
- hold is 1 exactly when state==STUFF. It is registered, so it asserts the cycle after the sixth 1 is sampled.
- Shift-register contract: the shift register advances on (shift_enable & ~hold). Exactly one raw bit is consumed per strobe, except during STUFF strobes.
- The stuffed 0 itself starts a new run, so cnt=0 after it.
- A stuffed bit is always emitted, even if stuff_en falls on the strobe that completes the run. The controller must not start EOP while hold=1.

## Timing
- There is one bit of latency. tx_bit is updated at the edge where shift_enable is sampled high, and bit_strobe is high in the following cycle.
- The shift_enable spacing must be at least 2 clocks. Behaviour with back-to-back strobes is undefined.
- hold rises one clock after the strobe that completes the run. It falls one clock after the next strobe, which is the strobe that emits the stuffed 0.
- Stream-length rule: the output bits per packet equal the raw bits plus one for each completed run of RUN_LENGTH 1s.
- A reset in mid-packet, including in STUFF, drops any pending stuff bit. The next packet starts with cnt=0.
- A stuff_en change with no shift_enable has no effect until the next strobe.

## Test plan
- **Reset values:** hold rst=1 for 2 clocks while strobing.
  - Required: tx_bit=1, hold=0, bit_strobe=0 throughout.
  - Required: after release, five 1s produce no hold.
- **Single stuff:** stuff_en=1, raw 1,1,1,1,1,1,1,0.
  - Required tx_bit sequence: 1,1,1,1,1,1,0,1,0.
  - Required: hold is high for exactly one bit period after the sixth 1.
  - Required: the seventh raw 1 is emitted only after the stuffed 0.
- **No stuff at five:** raw 1,1,1,1,1,0,1.
  - Required: output is identical to the input and hold is never 1.
- **Double stuff:** twelve consecutive raw 1s.
  - Required output: 1,1,1,1,1,1,0,1,1,1,1,1,1,0, which is 14 strobes with two hold pulses.
- **Stuff at packet end:** stuff_en falls on the same strobe as the sixth 1.
  - Required: hold=1, the next strobe emits 0, the state returns to IDLE, and hold=0.
  - Required: a following seven-1 stream with stuff_en=0 passes through unstuffed.
- **Reset while pending:** assert rst for one clock while hold=1.
  - Required: next cycle hold=0 and tx_bit=1, no stuffed 0 is emitted, and a fresh run needs six new 1s to stuff.

Source files
------------

// File: rtl/tx_bit_stuffer_if.sv
// Bit-level link between the TX shift register/controller and the bit stuffer.
// The stuffer uses the slave modport; the upstream controller uses master.
interface tx_bit_stuffer_if;
    logic shift_enable;
    logic stuff_en;
    logic raw_bit;
    logic tx_bit;
    logic bit_strobe;
    logic hold;

    modport master (
        output shift_enable, stuff_en, raw_bit,
        input  tx_bit, bit_strobe, hold
    );

    modport slave (
        input  shift_enable, stuff_en, raw_bit,
        output tx_bit, bit_strobe, hold
    );
endinterface

// File: rtl/tx_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every RUN_LENGTH consecutive 1s
// and raises hold so the shift register waits while the stuffed 0 is sent.
module tx_bit_stuffer #(
    parameter int unsigned RUN_LENGTH = 6
) (
    input logic              clk,
    input logic              rst,
    tx_bit_stuffer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STUFF
    } state_t;

    localparam logic [2:0] LAST = 3'(RUN_LENGTH - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       tx_bit_q;
    logic       bit_strobe_q;
    logic       hold_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tx_bit_q     <= 1'b1;
            bit_strobe_q <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            bit_strobe_q <= bus.shift_enable;
            if (bus.shift_enable) begin
                case (state)
                    STUFF: begin
                        // raw_bit is not consumed; the stuffed 0 opens a new run
                        tx_bit_q <= 1'b0;
                        cnt      <= '0;
                        hold_q   <= 1'b0;
                        state    <= bus.stuff_en ? ACTIVE : IDLE;
                    end
                    default: begin
                        tx_bit_q <= bus.raw_bit;
                        if (!bus.stuff_en) begin
                            cnt    <= '0;
                            hold_q <= 1'b0;
                            state  <= IDLE;
                        end else if (!bus.raw_bit) begin
                            cnt    <= '0;
                            hold_q <= 1'b0;
                            state  <= ACTIVE;
                        end else if (cnt == LAST) begin
                            cnt    <= '0;
                            hold_q <= 1'b1;
                            state  <= STUFF;
                        end else begin
                            cnt    <= cnt + 3'd1;
                            hold_q <= 1'b0;
                            state  <= ACTIVE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tx_bit     = tx_bit_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.hold       = hold_q;

endmodule

// File: tb/tb_tx_bit_stuffer.sv
// Self-checking bench for tx_bit_stuffer: a stream-level stuffing model feeds a
// scoreboard that is compared against tx_bit/bit_strobe/hold on every cycle.
module tb_tx_bit_stuffer;

    localparam int RL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_bit_stuffer_if bus ();

    tx_bit_stuffer #(.RUN_LENGTH(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic b;
        logic stuffed;
    } out_t;

    out_t exp_q[$];
    int   model_run = 0;

    // Stream-level rule: copy each raw bit; a stuffable 1 extends the run, anything
    // else clears it; a completed run appends a stuffed 0 and starts over.
    function automatic int stuff_model(input logic [31:0] bits, input logic [31:0] ens,
                                       input int n, inout int run,
                                       output logic [63:0] ob, output logic [63:0] os);
        int k = 0;
        ob = '0;
        os = '0;
        for (int i = 0; i < n; i++) begin
            ob[k] = bits[i];
            k++;
            if (ens[i] && bits[i]) run++;
            else run = 0;
            if (run == RL) begin
                ob[k] = 1'b0;
                os[k] = 1'b1;
                k++;
                run = 0;
            end
        end
        return k;
    endfunction

    logic rst_seen = 1'b0;
    logic se_seen  = 1'b0;
    logic armed    = 1'b0;
    out_t cmp_e;

    always @(posedge clk) begin
        rst_seen <= rst;
        se_seen  <= bus.shift_enable & ~rst;
        if (rst) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            if (rst_seen) begin
                check("rst_tx_bit", 64'(bus.tx_bit), 64'd1);
                check("rst_hold", 64'(bus.hold), 64'd0);
                check("rst_bit_strobe", 64'(bus.bit_strobe), 64'd0);
            end else begin
                check("bit_strobe", 64'(bus.bit_strobe), 64'(se_seen));
                if (bus.bit_strobe) begin
                    if (exp_q.size() == 0) begin
                        check("extra_output_bit", 64'(exp_q.size()), 64'd1);
                    end else begin
                        cmp_e = exp_q.pop_front();
                        check("tx_bit", 64'(bus.tx_bit), 64'(cmp_e.b));
                    end
                end
                check("hold", 64'(bus.hold), 64'(exp_q.size() > 0 && exp_q[0].stuffed));
            end
        end
    end

    task automatic do_reset(input int cycles, input bit strobe);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            bus.shift_enable = strobe && (c % 2 == 0);
            bus.raw_bit      = 1'b0;
            @(posedge clk);
            #1;
            bus.shift_enable = 1'b0;
        end
        rst = 1'b0;
        exp_q.delete();
        model_run = 0;
    endtask

    // Acts as the TX shift register: advances only on strobes taken while hold=0.
    task automatic play(input logic [31:0] bits, input logic [31:0] ens, input int n,
                        input bit drain, output int strobes, output int holds);
        logic [63:0] ob;
        logic [63:0] os;
        int          len;
        int          idx   = 0;
        int          guard = 0;
        logic        h;
        len = stuff_model(bits, ens, n, model_run, ob, os);
        for (int k = 0; k < len; k++) exp_q.push_back('{b: ob[k], stuffed: os[k]});
        strobes = 0;
        holds   = 0;
        while ((idx < n || (drain && bus.hold)) && guard < 200) begin
            h                = bus.hold;
            bus.raw_bit      = (idx < n) ? bits[idx] : 1'b1;
            bus.stuff_en     = (idx < n) ? ens[idx] : 1'b0;
            bus.shift_enable = 1'b1;
            @(posedge clk);
            #1;
            bus.shift_enable = 1'b0;
            strobes++;
            if (h) holds++;
            else idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        check("play_bounded", 64'(guard < 200), 64'd1);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        check("stream_drained", 64'(exp_q.size()), 64'd0);
    endtask

    int          s, h, n, r;
    logic [63:0] ob, os;

    initial begin
        bus.shift_enable = 1'b0;
        bus.stuff_en     = 1'b1;
        bus.raw_bit      = 1'b0;

        // Reset held two clocks while strobing
        do_reset(2, 1'b1);

        // Pin the model with hand-derived streams (LSB = first bit)
        r = 0;
        n = stuff_model(32'h7F, 32'hFF, 8, r, ob, os);
        check("model_single_len", 64'(n), 64'd9);
        check("model_single_bits", 64'(ob[8:0]), 64'h0BF);
        r = 0;
        n = stuff_model(32'hFFF, 32'hFFF, 12, r, ob, os);
        check("model_double_len", 64'(n), 64'd14);
        check("model_double_bits", 64'(ob[13:0]), 64'h1FBF);
        check("model_double_stuffed", 64'(os[13:0]), 64'h2040);
        r = 0;
        n = stuff_model(32'h5F, 32'h7F, 7, r, ob, os);
        check("model_five_len", 64'(n), 64'd7);
        check("model_five_bits", 64'(ob[6:0]), 64'h5F);

        // Five 1s after reset: no hold
        play(32'h1F, 32'h1F, 5, 1'b1, s, h);
        check("post_reset_strobes", 64'(s), 64'd5);
        check("post_reset_holds", 64'(h), 64'd0);
        settle();

        // Single stuff: 1x7 then 0
        do_reset(1, 1'b0);
        play(32'h7F, 32'hFF, 8, 1'b1, s, h);
        check("single_strobes", 64'(s), 64'd9);
        check("single_holds", 64'(h), 64'd1);
        settle();

        // Five 1s, 0, 1: passes through unchanged
        do_reset(1, 1'b0);
        play(32'h5F, 32'h7F, 7, 1'b1, s, h);
        check("five_strobes", 64'(s), 64'd7);
        check("five_holds", 64'(h), 64'd0);
        settle();

        // Twelve 1s: two stuffed zeros
        do_reset(1, 1'b0);
        play(32'hFFF, 32'hFFF, 12, 1'b1, s, h);
        check("double_strobes", 64'(s), 64'd14);
        check("double_holds", 64'(h), 64'd2);
        settle();

        // Stuff at packet end, then seven unstuffed 1s with stuff_en=0
        do_reset(1, 1'b0);
        play(32'h1FFF, 32'h3F, 13, 1'b1, s, h);
        check("pkt_end_strobes", 64'(s), 64'd14);
        check("pkt_end_holds", 64'(h), 64'd1);
        check("pkt_end_hold_low", 64'(bus.hold), 64'd0);
        settle();

        // Reset while a stuffed 0 is pending
        do_reset(1, 1'b0);
        play(32'h3F, 32'h3F, 6, 1'b0, s, h);
        check("pending_strobes", 64'(s), 64'd6);
        check("pending_hold", 64'(bus.hold), 64'd1);
        do_reset(1, 1'b0);
        check("pending_reset_hold", 64'(bus.hold), 64'd0);
        check("pending_reset_tx_bit", 64'(bus.tx_bit), 64'd1);
        play(32'h1F, 32'h1F, 5, 1'b1, s, h);
        check("fresh_five_holds", 64'(h), 64'd0);
        play(32'h1, 32'h1, 1, 1'b1, s, h);
        check("fresh_sixth_strobes", 64'(s), 64'd2);
        check("fresh_sixth_holds", 64'(h), 64'd1);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
